// File: rtl/jericalla_mejorada.sv
`default_nettype none
// ============================================================================
// Module   : jericalla_mejorada
// Brief    : Three-stage datapath (decode/regfile, ALU/demux, writeback/memory)
//            executing ADD, SUB, SLT and SW from a 17-bit instruction word.
// Revision : 1.0 - initial release
// ============================================================================
module jericalla_mejorada (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [16:0] main_bus,
  output logic [31:0] out
);

  localparam logic [1:0] C_OP_ADD  = 2'b00;
  localparam logic [1:0] C_OP_SUB  = 2'b01;
  localparam logic [1:0] C_OP_SLT  = 2'b10;
  localparam logic [1:0] C_OP_SW   = 2'b11;

  localparam logic [3:0] C_ALU_AND = 4'b0000;
  localparam logic [3:0] C_ALU_OR  = 4'b0001;
  localparam logic [3:0] C_ALU_ADD = 4'b0010;
  localparam logic [3:0] C_ALU_SUB = 4'b0110;
  localparam logic [3:0] C_ALU_SLT = 4'b0111;
  localparam logic [3:0] C_ALU_NOR = 4'b1100;

  // Instruction fields
  logic [1:0]  w_opcode;
  logic [4:0]  w_wa;
  logic [4:0]  w_ra_a;
  logic [4:0]  w_ra_b;

  // Control decode
  logic        w_we;
  logic        w_sel;
  logic        w_mw;
  logic        w_mr;
  logic [3:0]  w_aluop;

  // Architectural state
  logic [31:0] r_regs [32];
  logic [31:0] r_mem  [32];
  logic [31:0] r_out;

  // Stage 1
  logic [31:0] r_s1_a;
  logic [31:0] r_s1_b;
  logic        r_s1_sel;
  logic [3:0]  r_s1_op;
  logic        r_s1_we;
  logic [4:0]  r_s1_wa;
  logic        r_s1_w;
  logic        r_s1_r;

  // Stage 2
  logic [31:0] r_s2_res;
  logic [4:0]  r_s2_addr;
  logic [31:0] r_s2_data;
  logic        r_s2_we;
  logic [4:0]  r_s2_wa;
  logic        r_s2_w;
  logic        r_s2_r;

  // Datapath wires
  logic [31:0] w_data_a;
  logic [31:0] w_data_b;
  logic [31:0] w_alu_x;
  logic [31:0] w_alu_y;
  logic [4:0]  w_mem_addr;
  logic [31:0] w_mem_data;
  logic [31:0] w_alu_res;

  assign w_opcode = main_bus[16:15];
  assign w_wa     = main_bus[14:10];
  assign w_ra_a   = main_bus[9:5];
  assign w_ra_b   = main_bus[4:0];

  always_comb begin
    w_we    = 1'b0;
    w_sel   = 1'b0;
    w_mw    = 1'b0;
    w_mr    = 1'b0;
    w_aluop = C_ALU_AND;
    case (w_opcode)
      C_OP_ADD: begin
        w_we    = 1'b1;
        w_aluop = C_ALU_ADD;
      end
      C_OP_SUB: begin
        w_we    = 1'b1;
        w_aluop = C_ALU_SUB;
      end
      C_OP_SLT: begin
        w_we    = 1'b1;
        w_aluop = C_ALU_SLT;
      end
      C_OP_SW: begin
        w_sel   = 1'b1;
        w_mw    = 1'b1;
        w_mr    = 1'b1;
        w_aluop = C_ALU_AND;
      end
      default: begin
        w_we    = 1'b0;
      end
    endcase
  end

  // Write-through: the value retiring this cycle is visible to the reader,
  // which makes producers two or more cycles older hazard-free.
  assign w_data_a = (r_s2_we && (r_s2_wa == w_ra_a)) ? r_s2_res : r_regs[w_ra_a];
  assign w_data_b = (r_s2_we && (r_s2_wa == w_ra_b)) ? r_s2_res : r_regs[w_ra_b];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s1_sel <= 1'b0;
      r_s1_op  <= '0;
      r_s1_we  <= 1'b0;
      r_s1_wa  <= '0;
      r_s1_w   <= 1'b0;
      r_s1_r   <= 1'b0;
    end else begin
      r_s1_a   <= w_data_a;
      r_s1_b   <= w_data_b;
      r_s1_sel <= w_sel;
      r_s1_op  <= w_aluop;
      r_s1_we  <= w_we;
      r_s1_wa  <= w_wa;
      r_s1_w   <= w_mw;
      r_s1_r   <= w_mr;
    end
  end

  // Only the low five address bits reach memory, so only they are carried.
  assign w_alu_x    = r_s1_sel ? '0 : r_s1_a;
  assign w_alu_y    = r_s1_sel ? '0 : r_s1_b;
  assign w_mem_addr = r_s1_sel ? r_s1_a[4:0] : 5'd0;
  assign w_mem_data = r_s1_sel ? r_s1_b : '0;

  always_comb begin
    w_alu_res = '0;
    case (r_s1_op)
      C_ALU_AND: w_alu_res = w_alu_x & w_alu_y;
      C_ALU_OR:  w_alu_res = w_alu_x | w_alu_y;
      C_ALU_ADD: w_alu_res = w_alu_x + w_alu_y;
      C_ALU_SUB: w_alu_res = w_alu_x - w_alu_y;
      C_ALU_SLT: w_alu_res = {31'd0, ($signed(w_alu_x) < $signed(w_alu_y))};
      C_ALU_NOR: w_alu_res = ~(w_alu_x | w_alu_y);
      default:   w_alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_res  <= '0;
      r_s2_addr <= '0;
      r_s2_data <= '0;
      r_s2_we   <= 1'b0;
      r_s2_wa   <= '0;
      r_s2_w    <= 1'b0;
      r_s2_r    <= 1'b0;
    end else begin
      r_s2_res  <= w_alu_res;
      r_s2_addr <= w_mem_addr;
      r_s2_data <= w_mem_data;
      r_s2_we   <= r_s1_we;
      r_s2_wa   <= r_s1_wa;
      r_s2_w    <= r_s1_w;
      r_s2_r    <= r_s1_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'(i);
      end
    end else if (r_s2_we) begin
      r_regs[r_s2_wa] <= r_s2_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_mem[i] <= '0;
      end
    end else if (r_s2_w) begin
      r_mem[r_s2_addr] <= r_s2_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else if (r_s2_r) begin
      r_out <= r_s2_w ? r_s2_data : r_mem[r_s2_addr];
    end
  end

  assign out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_jericalla_mejorada.sv
`default_nettype none
// Testbench for jericalla_mejorada: directed vector table, pipeline corner
// sequences, and a randomized run against an instruction-level model.
module tb_jericalla_mejorada;

  localparam logic [16:0] C_FILL = 17'b10_11111_00000_00000;  // r31 = (r0 < r0)
  localparam int          C_NRAND = 400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [16:0] main_bus = C_FILL;
  logic [31:0] out;

  int checks = 0;
  int errors = 0;

  jericalla_mejorada dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .main_bus (main_bus),
    .out      (out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] first;
    logic [16:0] second;
    int          ridx;
    logic [31:0] rexp;
    int          midx;
    logic [31:0] mexp;
    logic [31:0] oexp;
  } vec_t;

  vec_t vecs [3];

  logic [31:0] mreg [32];
  logic [31:0] mmem [32];
  logic [31:0] sreg [32];
  logic [31:0] smem [32];
  logic [31:0] mout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    main_bus = C_FILL;
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [16:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] exp_out;
    logic        pv;
    logic        p_sw;
    logic [4:0]  pidx;
    logic [31:0] pval;

    vecs[0] = '{17'b00_00100_00000_00001, 17'b11_00000_00111_00100, 4, 32'h0000_0001, 7, 32'h0000_0001, 32'h0000_0001};
    vecs[1] = '{17'b01_00101_00001_00010, 17'b11_00000_01000_00101, 5, 32'hFFFF_FFFF, 8, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[2] = '{17'b10_00110_00010_00011, 17'b11_00000_01001_00110, 6, 32'h0000_0001, 9, 32'h0000_0001, 32'h0000_0001};

    // Reset state, checked before any clock edge to confirm asynchronous clear
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_out_async", out, 32'h0);
    tick(2);
    for (int k = 0; k < 32; k++) begin
      check("reset_reg", dut.r_regs[5'(k)], 32'(k));
      check("reset_mem", dut.r_mem[5'(k)], 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: producer then dependent SW, each held for two rises
    for (int v = 0; v < 3; v++) begin
      main_bus = vecs[v].first;
      tick(2);
      main_bus = vecs[v].second;
      tick(2);
      main_bus = C_FILL;
      tick(2);
      check("vec_out", out, vecs[v].oexp);
      check("vec_reg", dut.r_regs[5'(vecs[v].ridx)], vecs[v].rexp);
      check("vec_mem", dut.r_mem[5'(vecs[v].midx)], vecs[v].mexp);
    end

    // Asynchronous reset mid-cycle clears out and restores registers
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out", out, 32'h0);
    check("async_r4", dut.r_regs[5'd4], 32'd4);
    check("async_mem7", dut.r_mem[5'd7], 32'h0);
    tick(1);
    @(negedge clk);
    rst_n = 1'b1;

    // One-cycle hazard: SW reads the stale r4
    main_bus = 17'b00_00100_00000_00001;
    tick(1);
    main_bus = 17'b11_00000_00111_00100;
    tick(1);
    main_bus = C_FILL;
    tick(2);
    check("hazard_out", out, 32'd4);
    check("hazard_mem7", dut.r_mem[5'd7], 32'd4);
    check("hazard_r4", dut.r_regs[5'd4], 32'd1);

    // Reset between the first and second rise of ADD r10 = r1 + r2
    do_reset();
    main_bus = 17'b00_01010_00001_00010;
    tick(1);
    #2;
    rst_n    = 1'b0;
    main_bus = C_FILL;
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);
    check("midrst_r10", dut.r_regs[5'd10], 32'd10);
    check("midrst_out", out, 32'h0);
    for (int k = 0; k < 32; k++) begin
      check("midrst_mem", dut.r_mem[5'(k)], 32'h0);
    end

    // Signed SLT with a negative operand produced by SUB
    do_reset();
    main_bus = 17'b01_00001_00001_00010;
    tick(2);
    main_bus = 17'b10_00011_00001_00010;
    tick(2);
    main_bus = C_FILL;
    tick(2);
    check("slt_r1", dut.r_regs[5'd1], 32'hFFFF_FFFF);
    check("slt_r3", dut.r_regs[5'd3], 32'd1);

    // Randomized run against an instruction-level model. An instruction sees
    // the effects of everything issued two or more cycles earlier.
    do_reset();
    for (int k = 0; k < 32; k++) begin
      mreg[k] = 32'(k);
      mmem[k] = 32'h0;
    end
    mout = 32'h0;
    pv   = 1'b0;
    p_sw = 1'b0;
    pidx = 5'd0;
    pval = 32'h0;
    for (int i = 0; i < C_NRAND; i++) begin
      ins = 17'($urandom);
      a   = mreg[ins[9:5]];
      b   = mreg[ins[4:0]];
      case (ins[16:15])
        2'b00:   res = a + b;
        2'b01:   res = a - b;
        2'b10:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: res = b;
      endcase
      exp_out = mout;
      sreg    = mreg;
      smem    = mmem;
      if (pv) begin
        if (p_sw) begin
          mmem[pidx] = pval;
          mout       = pval;
        end else begin
          mreg[pidx] = pval;
        end
      end
      pv   = 1'b1;
      p_sw = (ins[16:15] == 2'b11);
      pidx = p_sw ? a[4:0] : ins[14:10];
      pval = res;
      main_bus = ins;
      tick(1);
      check("rand_out", out, exp_out);
    end
    for (int k = 0; k < 32; k++) begin
      check("rand_reg", dut.r_regs[5'(k)], sreg[k]);
      check("rand_mem", dut.r_mem[5'(k)], smem[k]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jericalla_mejorada.md
JERICALLA_MEJORADA -- requirements
Module: jericalla_mejorada

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset, named clk and rst_n.
REQ-002 The block SHALL have these ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- main_bus  input  17  instruction word.
- out  output  32  registered memory read-data.
REQ-003 main_bus SHALL be decoded as follows:
- [16:15] opcode.
- [14:10] WA, the write register.
- [9:5] RA_A, source register A.
- [4:0] RA_B, source register B.

Function
REQ-004 Opcodes SHALL decode as follows:
- 00 ADD: rWA = rA + rB.
- 01 SUB: rWA = rA - rB.
- 10 SLT: rWA = (signed rA < signed rB) ? 1 : 0.
- 11 SW: mem[rA[4:0]] = rB, with no register write.
REQ-005 Control decode SHALL produce:
- Register write-enable: 1 for opcodes 00, 01 and 10.
- ALU op: ADD 0010, SUB 0110, SLT 0111, SW 0000.
- Demux select: 0 selects the ALU, 1 selects memory (SW).
- Memory write W and memory read R: both 1 for SW only.
REQ-006 The ALU SHALL be combinational, take 32-bit X and Y and a 4-bit op, and produce:
- 0000 AND, 0001 OR.
- 0010 ADD, 0110 SUB, both modulo 2^32 with no flags.
- 0111 signed SLT.
- 1100 NOR.
- Any other code: 0.
REQ-007 The register file SHALL have 32 registers of 32 bits, two combinational read ports (RA_A, RA_B) and one write port written on the rising clk edge when the delayed write-enable is 1.
REQ-008 Register 0 SHALL be an ordinary writable register.
REQ-009 When the write port and a read port address the same register in the same cycle, the read port SHALL return the data being written (write-through bypass).
REQ-010 Data memory SHALL hold 32 words of 32 bits, addressed by address[4:0]; upper address bits are ignored.
REQ-011 Stage 1 pipeline register, captured on clk rise: dataA, dataB, demux select, ALU op, write-enable, WA, W, R.
REQ-012 After stage 1, a demux SHALL route the stage-1 dataA and dataB to the ALU inputs when select is 0 and to the memory path when select is 1; the unselected side is driven with 0.
REQ-013 Stage 2 pipeline register, captured on clk rise: ALU result, memory address (demuxed A), memory write data (demuxed B), write-enable, WA, W, R.
REQ-014 Register writeback SHALL occur on the third rising edge after the instruction is presented, using the stage-2 ALU result, WA and write-enable.
REQ-015 The memory write (mem[addr] = data when stage-2 W is 1) SHALL also occur on the third rising edge.
REQ-016 On the third rising edge, when stage-2 R is 1, out SHALL load the read data: the stage-2 write data if stage-2 W is also 1, otherwise mem[addr].
REQ-017 out SHALL hold its value when stage-2 R is 0.
REQ-018 Each instruction SHALL have a latency of 3 clk rises from presentation to architectural effect, and a new instruction may be presented every cycle.
REQ-019 Operands SHALL be correct for a dependent instruction presented 2 or more cycles after its producer, via the REQ-009 bypass.
REQ-020 For a dependent instruction presented exactly 1 cycle after its producer, the stale register value SHALL be read; no further forwarding or stalling is provided.
REQ-021 Held or repeated instructions SHALL re-execute on every edge; idempotent instructions repeated give the same result.

Reset
REQ-022 Assertion of rst_n low SHALL take effect immediately, independent of clk.
REQ-023 While rst_n is low:
- All stage-1 and stage-2 registers are 0, including write-enable, W and R.
- out is 0.
- Register i holds the value i, for i = 0..31.
- All memory words are 0.
REQ-024 Reset asserted mid-instruction SHALL cancel all in-flight writes; no register or memory write occurs from an instruction whose stage registers were cleared.
REQ-025 After rst_n is released, the first instruction SHALL be captured on the first clk rise.

Verification
REQ-026 The bench SHALL apply reset, then present each of the following for two clk rises:
- ADD 00_00100_00000_00001, then SW 11_00000_00111_00100. Required: r4 = 1, mem[7] = 1, and out = 0x00000001 after the SW's third edge.
- SUB 01_00101_00001_00010, then SW 11_00000_01000_00101. Required: r5 = 0xFFFFFFFF, mem[8] = 0xFFFFFFFF, and out = 0xFFFFFFFF.
- SLT 10_00110_00010_00011, then SW 11_00000_01001_00110. Required: r6 = 1, mem[9] = 1, and out = 1.
REQ-027 The bench SHALL check the 1-cycle hazard: ADD r4 = r0 + r1 presented on consecutive cycles with SW mem[r7] = r4. Required: the stored value is 4, the stale reset value.
REQ-028 The bench SHALL check reset mid-pipeline: assert rst_n low between the 1st and 2nd rise of an ADD to r10. Required: r10 stays 10, out = 0, and memory is unchanged at 0.
REQ-029 The bench SHALL check signed SLT: with r1 = 0xFFFFFFFF (stored via SUB) and r2 = 2, SLT r3 = r1 < r2. Required: r3 = 1.
